// File: rtl/mmio_btn_in_if.sv
// Load/store bus between the datapath data-memory decode and the button input peripheral.
// The master drives the address and store side; the slave returns the window hit and read data.
interface mmio_btn_in_if;
  logic [31:0] addr;
  logic        w_en;
  logic [31:0] w_data;
  logic        hit;
  logic [31:0] r_data;

  modport master (output addr, output w_en, output w_data, input hit, input r_data);
  modport slave  (input addr, input w_en, input w_data, output hit, output r_data);
endinterface

// File: rtl/mmio_btn_in.sv
// Memory-mapped button/switch input: 2-flop sync, per-pin debounce, and level, raw and
// sticky W1C edge-flag registers. Reads are combinational; flag clears land on the clock edge.
module mmio_btn_in #(
  parameter int unsigned N_IN            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] pin_in,
  mmio_btn_in_if.slave    bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0] sync1_q, sync2_q;
  logic [N_IN-1:0] stable_q, stable_d;
  logic [N_IN-1:0] rise_q, rise_d;
  logic [N_IN-1:0] fall_q, fall_d;
  logic [CW-1:0]   cnt_q [N_IN];
  logic [CW-1:0]   cnt_d [N_IN];
  logic [N_IN-1:0] accept;
  logic [N_IN-1:0] clr_rise, clr_fall;
  logic [1:0]      sel;
  logic            wr;
  logic            unused_bits;

  assign bus.hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign sel         = bus.addr[3:2];
  assign wr          = bus.hit && bus.w_en;
  assign unused_bits = ^{bus.addr[1:0], bus.w_data};

  // Counter only runs while sync2 disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        accept[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Clear first, then OR in new edges so a same-edge set wins.
  always_comb begin
    clr_rise = (wr && sel == 2'd1) ? bus.w_data[N_IN-1:0] : '0;
    clr_fall = (wr && sel == 2'd2) ? bus.w_data[N_IN-1:0] : '0;
    rise_d   = (rise_q & ~clr_rise) | (accept & sync2_q);
    fall_d   = (fall_q & ~clr_fall) | (accept & ~sync2_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < int'(N_IN); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= pin_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < int'(N_IN); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    bus.r_data = 32'h0;
    if (bus.hit) begin
      case (sel)
        2'd0:    bus.r_data = 32'(stable_q);
        2'd1:    bus.r_data = 32'(rise_q);
        2'd2:    bus.r_data = 32'(fall_q);
        default: bus.r_data = 32'(sync2_q);
      endcase
    end
  end

endmodule
